// File: rtl/uart_arb_pkg.sv
// ----------------------------------------------------------------------------
// uart_arb_pkg
//   Shared types and defaults for the UART transmit arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, LOCK)
//   - *_DEF       : default parameter values for uart_tx_arb
//   - cnt_w()     : width of a counter that must hold 0..max_val without
//                   wrapping (never narrower than one bit)
// ----------------------------------------------------------------------------
package uart_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int MAX_PKT_DEF = 64;
  localparam int IDLE_TO_DEF = 255;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // A disabled feature (max_val == 0) still gets a 1-bit counter so that no
  // zero-width vectors appear downstream.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Searches i_req starting at i_ptr+1 and
//   wrapping, returning the first set bit as a one-hot grant and its index.
//   Outputs are all-zero when no request is set.
//   Ports:
//     i_req  [N]  request vector
//     i_ptr  [IW] index of the previous winner
//     o_gnt  [N]  one-hot winner
//     o_idx  [IW] winner index
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    int              cand;
    logic [IW-1:0]   cand_idx;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise a latch is inferred for the
    // paths that leave it untouched.
    o_gnt    = '0;
    o_idx    = '0;
    cand     = 0;
    cand_idx = '0;
    // Walk from the farthest candidate to the nearest so the nearest
    // requester after i_ptr overwrites the others and wins.
    for (int i = N; i >= 1; i--) begin
      cand     = (int'(i_ptr) + i) % N;
      cand_idx = IW'(cand);
      if (i_req[cand_idx]) begin
        o_gnt           = '0;
        o_gnt[cand_idx] = 1'b1;
        o_idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// ----------------------------------------------------------------------------
// uart_tx_arb
//   Shares one UART transmitter between N_REQ byte producers. Round-robin
//   arbitration with packet locking: once a requester is granted it keeps the
//   UART until it sends a byte flagged last, sends MAX_PKT bytes, or leaves
//   its valid low for IDLE_TO cycles (IDLE_TO = 0 disables the timeout).
//   A one-entry output register with a skid-style ready feeds uart_ctrl.
//   Ports:
//     clk_i, rst_n_i    clock (UART domain), async active-low reset
//     req_v_i    [N]    per-requester byte valid
//     req_data_i [N*W]  packed bytes, requester k at [k*W +: W]
//     req_last_i [N]    final byte of a packet, sampled with req_v_i
//     req_rdy_o  [N]    per-requester accept (at most one bit high)
//     gnt_o      [N]    one-hot lock owner, zero when idle
//     tx_data_o  [W]    byte to uart_ctrl
//     tx_v_o            tx_data_o valid
//     tx_rdy_i          uart_ctrl accepts the byte this cycle
//     busy_o            lock held or byte pending
// ----------------------------------------------------------------------------
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_PKT = MAX_PKT_DEF,
  parameter int IDLE_TO = IDLE_TO_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [N_REQ-1:0]          req_v_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  input  logic [N_REQ-1:0]          req_last_i,
  output logic [N_REQ-1:0]          req_rdy_o,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [DATA_W-1:0]         tx_data_o,
  output logic                      tx_v_o,
  input  logic                      tx_rdy_i,
  output logic                      busy_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = cnt_w(MAX_PKT);
  localparam int TW = cnt_w(IDLE_TO);

  arb_state_e        r_state, w_state_nxt;
  logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [IW-1:0]     r_gnt_idx, w_gnt_idx_nxt;
  logic [IW-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [BW-1:0]     r_byte_cnt, w_byte_cnt_nxt, w_byte_cnt_inc;
  logic [TW-1:0]     r_idle_cnt, w_idle_cnt_nxt, w_idle_cnt_inc;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_v;

  logic [N_REQ-1:0]  w_pick_gnt;
  logic [IW-1:0]     w_pick_idx;
  logic [DATA_W-1:0] w_own_data;
  logic              w_own_v, w_own_last;
  logic              w_skid_ok, w_xfer_in, w_xfer_out, w_release;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .i_req (req_v_i),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  // Owner's request lanes, selected by the registered grant index.
  always_comb begin
    w_own_data = '0;
    w_own_v    = 1'b0;
    w_own_last = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_gnt_idx == IW'(k)) begin
        w_own_data = req_data_i[k*DATA_W +: DATA_W];
        w_own_v    = req_v_i[k];
        w_own_last = req_last_i[k];
      end
    end
  end

  // The output register can take a new byte when it is empty or being
  // drained this very cycle, so back-to-back UART accepts see no bubble.
  assign w_skid_ok  = ~r_tx_v | tx_rdy_i;
  assign req_rdy_o  = (r_state == LOCK && w_skid_ok) ? r_gnt : '0;
  assign w_xfer_in  = |(req_v_i & req_rdy_o);
  assign w_xfer_out = r_tx_v & tx_rdy_i;

  assign w_byte_cnt_inc = r_byte_cnt + 1'b1;
  assign w_idle_cnt_inc = r_idle_cnt + 1'b1;

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gnt_idx_nxt  = r_gnt_idx;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_byte_cnt_nxt = r_byte_cnt;
    w_idle_cnt_nxt = r_idle_cnt;
    w_release      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|req_v_i) begin
          w_state_nxt   = LOCK;
          w_gnt_nxt     = w_pick_gnt;
          w_gnt_idx_nxt = w_pick_idx;
          w_rr_ptr_nxt  = w_pick_idx;
        end
      end
      LOCK: begin
        if (w_xfer_in) begin
          w_byte_cnt_nxt = w_byte_cnt_inc;
          w_idle_cnt_nxt = '0;
          w_release      = w_own_last || (w_byte_cnt_inc == BW'(MAX_PKT));
        end else if (!w_own_v && (IDLE_TO != 0)) begin
          // A stalled owner (valid high, UART busy) is not idle; only a
          // silent owner counts toward the timeout.
          w_idle_cnt_nxt = w_idle_cnt_inc;
          w_release      = (w_idle_cnt_inc == TW'(IDLE_TO));
        end
        // Release does not wait for the output register to drain.
        if (w_release) begin
          w_state_nxt    = IDLE;
          w_gnt_nxt      = '0;
          w_byte_cnt_nxt = '0;
          w_idle_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_gnt_idx  <= '0;
      r_rr_ptr   <= IW'(N_REQ - 1);
      r_byte_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_idx  <= w_gnt_idx_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
    end
  end

  // One-entry output register: load wins over drain, so a simultaneous
  // accept and load replaces the byte and keeps valid high.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tx_v    <= 1'b0;
      r_tx_data <= '0;
    end else if (w_xfer_in) begin
      r_tx_v    <= 1'b1;
      r_tx_data <= w_own_data;
    end else if (w_xfer_out) begin
      r_tx_v    <= 1'b0;
    end
  end

  assign gnt_o     = r_gnt;
  assign tx_v_o    = r_tx_v;
  assign tx_data_o = r_tx_data;
  assign busy_o    = (r_state == LOCK) | r_tx_v;

endmodule

// File: tb/tb_uart_tx_arb.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arb
//   Self-checking bench for uart_tx_arb. Producers are per-requester byte
//   queues; a packet-level model predicts the grant order and the byte
//   stream seen by the UART, and per-cycle checks cover handshakes,
//   the output register and lock release timing.
// ----------------------------------------------------------------------------
module tb_uart_tx_arb;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXP = 64;
  localparam int ITO  = 8;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic [N-1:0]    req_v_i, req_last_i, req_rdy_o, gnt_o;
  logic [N*DW-1:0] req_data_i;
  logic [DW-1:0]   tx_data_o;
  logic            tx_v_o, tx_rdy_i, busy_o;

  int n_cmp = 0;
  int n_err = 0;

  // Producer streams: {last, data} per byte.
  logic [DW:0]   src_q [N][$];
  int            exp_gnt_q[$];
  logic [DW-1:0] exp_byte_q[$];
  int            obs_gnt_q[$];
  logic [DW-1:0] obs_byte_q[$];
  int            obs_cyc_q[$];

  uart_tx_arb #(
    .N_REQ   (N),
    .DATA_W  (DW),
    .MAX_PKT (MAXP),
    .IDLE_TO (ITO)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .req_v_i    (req_v_i),
    .req_data_i (req_data_i),
    .req_last_i (req_last_i),
    .req_rdy_o  (req_rdy_o),
    .gnt_o      (gnt_o),
    .tx_data_o  (tx_data_o),
    .tx_v_o     (tx_v_o),
    .tx_rdy_i   (tx_rdy_i),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int idx_of(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int k = N - 1; k >= 0; k--) if (v[k]) r = k;
    return r;
  endfunction

  function automatic bit is_onehot(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  task automatic push_byte(input int k, input logic [DW-1:0] d, input logic last);
    src_q[k].push_back({last, d});
  endtask

  task automatic apply_reset();
    rst_n_i    = 1'b0;
    req_v_i    = '0;
    req_last_i = '0;
    req_data_i = '0;
    tx_rdy_i   = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  // Packet-level model: whenever the UART is free, the next owner is the
  // first requester after the previous winner with anything queued; it then
  // sends until a last byte, MAX_PKT bytes, or its stream runs dry (timeout).
  task automatic model_run();
    logic [DW:0] m_q [N][$];
    logic [DW:0] e;
    int ptr, w, c, cnt;
    for (int k = 0; k < N; k++) m_q[k] = src_q[k];
    exp_gnt_q.delete();
    exp_byte_q.delete();
    ptr = N - 1;
    forever begin
      w = -1;
      for (int i = 1; i <= N; i++) begin
        c = (ptr + i) % N;
        if (w < 0 && m_q[c].size() > 0) w = c;
      end
      if (w < 0) break;
      exp_gnt_q.push_back(w);
      ptr = w;
      cnt = 0;
      while (m_q[w].size() > 0 && cnt < MAXP) begin
        e = m_q[w].pop_front();
        exp_byte_q.push_back(e[DW-1:0]);
        cnt++;
        if (e[DW]) break;
      end
    end
  endtask

  // Drives the producer queues until everything has drained, checking each
  // cycle, then compares observed grants and bytes against the model.
  // rdy_mode: 0 always ready, 1 random, 2 ready except a 10-cycle stall.
  task automatic run_engine(input int rdy_mode, input int stall_at, input int budget);
    logic [N-1:0]  p_gnt, p_req_v, in_acc, exp_rdy;
    logic          p_in, p_hold, p_out, p_rel, out_acc, rel, all_empty, ok;
    logic [DW-1:0] p_data, p_in_byte, in_byte;
    logic [DW:0]   head;
    int cyc, lock_bytes, idle, own;
    p_gnt = '0; p_req_v = '0; p_in = 1'b0; p_hold = 1'b0; p_out = 1'b0;
    p_rel = 1'b0; p_data = '0; p_in_byte = '0;
    cyc = 0; lock_bytes = 0; idle = 0;
    model_run();
    obs_gnt_q.delete();
    obs_byte_q.delete();
    obs_cyc_q.delete();
    forever begin
      @(negedge clk_i);
      for (int k = 0; k < N; k++) begin
        if (src_q[k].size() > 0) begin
          head = src_q[k][0];
          req_v_i[k]    = 1'b1;
          req_last_i[k] = head[DW];
          req_data_i[k*DW +: DW] = head[DW-1:0];
        end else begin
          req_v_i[k]    = 1'b0;
          req_last_i[k] = 1'b0;
          req_data_i[k*DW +: DW] = DW'($urandom);
        end
      end
      case (rdy_mode)
        0:       tx_rdy_i = 1'b1;
        1:       tx_rdy_i = ($urandom_range(0, 3) != 0);
        default: tx_rdy_i = !(cyc >= stall_at && cyc < stall_at + 10);
      endcase
      #1;
      // Grant: release when predicted, otherwise hold; from idle, a grant
      // appears one cycle after any request and goes to a requester.
      if (p_rel)              ok = (gnt_o == '0);
      else if (p_gnt != '0)   ok = (gnt_o == p_gnt);
      else if (p_req_v != '0) ok = is_onehot(gnt_o) && ((gnt_o & p_req_v) != '0);
      else                    ok = (gnt_o == '0);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL gnt cyc=%0d: got %b, prev gnt %b prev req_v %b release_due %0b",
                 cyc, gnt_o, p_gnt, p_req_v, p_rel);
      end
      if (p_gnt == '0 && gnt_o != '0) obs_gnt_q.push_back(idx_of(gnt_o));
      // Output register behaviour.
      if (p_in)        ok = tx_v_o && (tx_data_o == p_in_byte);
      else if (p_hold) ok = tx_v_o && (tx_data_o == p_data);
      else             ok = !tx_v_o;
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL txreg cyc=%0d: got v=%0b d=%h, want load=%0b(%h) hold=%0b(%h)",
                 cyc, tx_v_o, tx_data_o, p_in, p_in_byte, p_hold, p_data);
      end
      exp_rdy = (gnt_o != '0 && (!tx_v_o || tx_rdy_i)) ? gnt_o : '0;
      n_cmp++;
      if (req_rdy_o !== exp_rdy) begin
        n_err++;
        $display("FAIL req_rdy cyc=%0d: got %b want %b", cyc, req_rdy_o, exp_rdy);
      end
      n_cmp++;
      if (busy_o !== ((gnt_o != '0) || tx_v_o)) begin
        n_err++;
        $display("FAIL busy cyc=%0d: got %0b want %0b", cyc, busy_o, (gnt_o != '0) || tx_v_o);
      end
      // Handshakes of this cycle and lock bookkeeping.
      in_acc  = req_v_i & req_rdy_o;
      out_acc = tx_v_o & tx_rdy_i;
      if (out_acc) begin
        obs_byte_q.push_back(tx_data_o);
        obs_cyc_q.push_back(cyc);
      end
      rel = 1'b0;
      in_byte = '0;
      if (gnt_o != '0) begin
        own = idx_of(gnt_o);
        if (in_acc[own]) begin
          lock_bytes++;
          idle = 0;
          in_byte = req_data_i[own*DW +: DW];
          rel = req_last_i[own] || (lock_bytes == MAXP);
        end else if (!req_v_i[own]) begin
          idle++;
          rel = (idle == ITO);
        end
      end else begin
        lock_bytes = 0;
        idle = 0;
      end
      all_empty = 1'b1;
      for (int k = 0; k < N; k++) if (src_q[k].size() > 0) all_empty = 1'b0;
      if (all_empty && gnt_o == '0 && !tx_v_o) break;
      if (cyc >= budget) begin
        n_cmp++;
        n_err++;
        $display("FAIL drain_timeout: %0d cycles elapsed, budget %0d", cyc, budget);
        break;
      end
      p_gnt = gnt_o; p_req_v = req_v_i; p_in = |in_acc; p_in_byte = in_byte;
      p_hold = tx_v_o && !tx_rdy_i; p_out = out_acc; p_data = tx_data_o; p_rel = rel;
      @(posedge clk_i);
      for (int k = 0; k < N; k++) if (in_acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      cyc++;
    end
    req_v_i = '0;
    req_last_i = '0;
    for (int k = 0; k < N; k++) src_q[k].delete();
    n_cmp++;
    if (obs_gnt_q.size() != exp_gnt_q.size()) begin
      n_err++;
      $display("FAIL grant_count: got %0d want %0d", obs_gnt_q.size(), exp_gnt_q.size());
    end
    for (int i = 0; i < exp_gnt_q.size() && i < obs_gnt_q.size(); i++) begin
      n_cmp++;
      if (obs_gnt_q[i] != exp_gnt_q[i]) begin
        n_err++;
        $display("FAIL grant_order[%0d]: got %0d want %0d", i, obs_gnt_q[i], exp_gnt_q[i]);
      end
    end
    n_cmp++;
    if (obs_byte_q.size() != exp_byte_q.size()) begin
      n_err++;
      $display("FAIL byte_count: got %0d want %0d", obs_byte_q.size(), exp_byte_q.size());
    end
    for (int i = 0; i < exp_byte_q.size() && i < obs_byte_q.size(); i++) begin
      n_cmp++;
      if (obs_byte_q[i] !== exp_byte_q[i]) begin
        n_err++;
        $display("FAIL byte[%0d]: got %h want %h", i, obs_byte_q[i], exp_byte_q[i]);
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    n_cmp++;
    if (req_rdy_o !== '0) begin n_err++; $display("FAIL %s req_rdy: got %b want 0", tag, req_rdy_o); end
    n_cmp++;
    if (gnt_o !== '0) begin n_err++; $display("FAIL %s gnt: got %b want 0", tag, gnt_o); end
    n_cmp++;
    if (tx_v_o !== 1'b0) begin n_err++; $display("FAIL %s tx_v: got %b want 0", tag, tx_v_o); end
    n_cmp++;
    if (tx_data_o !== '0) begin n_err++; $display("FAIL %s tx_data: got %h want 0", tag, tx_data_o); end
    n_cmp++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL %s busy: got %b want 0", tag, busy_o); end
  endtask

  task automatic test_reset();
    rst_n_i    = 1'b0;
    req_v_i    = '1;
    req_last_i = '1;
    req_data_i = {$urandom};
    tx_rdy_i   = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check_outputs_zero("reset");
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    n_cmp++;
    if (gnt_o !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_first_gnt: got %b want 0001", gnt_o);
    end
    n_cmp++;
    if (tx_v_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_byte_in_idle: tx_v got %b want 0", tx_v_o);
    end
  endtask

  task automatic test_single_packet();
    apply_reset();
    push_byte(2, 8'h48, 1'b0);
    push_byte(2, 8'h69, 1'b0);
    push_byte(2, 8'h21, 1'b1);
    run_engine(0, 0, 200);
    for (int i = 1; i < obs_cyc_q.size(); i++) begin
      n_cmp++;
      if (obs_cyc_q[i] != obs_cyc_q[i-1] + 1) begin
        n_err++;
        $display("FAIL single_no_bubble[%0d]: got cycle %0d want %0d", i, obs_cyc_q[i], obs_cyc_q[i-1] + 1);
      end
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < N; k++) push_byte(k, DW'(k * 16 + p), 1'b1);
    run_engine(0, 0, 400);
    for (int i = 0; i < 16 && i < obs_gnt_q.size(); i++) begin
      n_cmp++;
      if (obs_gnt_q[i] != i % N) begin
        n_err++;
        $display("FAIL fairness[%0d]: got %0d want %0d", i, obs_gnt_q[i], i % N);
      end
    end
  endtask

  task automatic test_back_pressure();
    apply_reset();
    for (int i = 0; i < 5; i++) push_byte(0, DW'(8'h10 + i), i == 4);
    run_engine(2, 4, 200);
    for (int i = 0; i < 5 && i < obs_byte_q.size(); i++) begin
      n_cmp++;
      if (obs_byte_q[i] !== DW'(8'h10 + i)) begin
        n_err++;
        $display("FAIL backpressure_seq[%0d]: got %h want %h", i, obs_byte_q[i], 8'h10 + i);
      end
    end
  endtask

  task automatic test_forced_release();
    int want [3];
    want = '{1, 3, 1};
    apply_reset();
    for (int i = 0; i < 70; i++) push_byte(1, DW'(i), 1'b0);
    for (int i = 0; i < 3; i++) push_byte(3, DW'(8'hC0 + i), i == 2);
    run_engine(0, 0, 1000);
    n_cmp++;
    if (obs_gnt_q.size() != 3) begin
      n_err++;
      $display("FAIL maxpkt_grants: got %0d grants want 3", obs_gnt_q.size());
    end
    for (int i = 0; i < 3 && i < obs_gnt_q.size(); i++) begin
      n_cmp++;
      if (obs_gnt_q[i] != want[i]) begin
        n_err++;
        $display("FAIL maxpkt_order[%0d]: got %0d want %0d", i, obs_gnt_q[i], want[i]);
      end
    end
  endtask

  task automatic test_idle_timeout();
    apply_reset();
    push_byte(0, 8'h5A, 1'b0);
    push_byte(0, 8'hA5, 1'b0);
    run_engine(1, 0, 200);
  endtask

  task automatic test_random();
    int npk, len;
    for (int it = 0; it < 4; it++) begin
      apply_reset();
      for (int k = 0; k < N; k++) begin
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 8);
          for (int b = 0; b < len; b++) push_byte(k, DW'($urandom), b == len - 1);
        end
      end
      run_engine(1, 0, 2000);
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    @(negedge clk_i);
    req_v_i    = 4'b0100;
    req_last_i = '0;
    req_data_i[2*DW +: DW] = 8'hA5;
    tx_rdy_i   = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    n_cmp++;
    if (!(tx_v_o === 1'b1 && gnt_o === 4'b0100 && tx_data_o === 8'hA5)) begin
      n_err++;
      $display("FAIL midpkt_setup: got v=%b gnt=%b d=%h want v=1 gnt=0100 d=a5", tx_v_o, gnt_o, tx_data_o);
    end
    #1 rst_n_i = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    req_v_i  = '0;
    tx_rdy_i = 1'b1;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(3, DW'(8'h30 + i), i == 3);
    run_engine(0, 0, 200);
  endtask

  initial begin
    rst_n_i    = 1'b0;
    req_v_i    = '0;
    req_last_i = '0;
    req_data_i = '0;
    tx_rdy_i   = 1'b1;
    test_reset();
    test_single_packet();
    test_fairness();
    test_back_pressure();
    test_forced_release();
    test_idle_timeout();
    test_random();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
